// File: rtl/wdog_sched_pkg.sv
// rtl/wdog_sched_pkg.sv - watchdog register map and scheduler FSM encoding
package wdog_sched_pkg;

  localparam logic [7:0]  ADDR_SAFEGUARD = 8'h01;
  localparam logic [7:0]  ADDR_KICK      = 8'h04;
  localparam logic [7:0]  ADDR_LOAD      = 8'h08;
  localparam logic [31:0] SAFEGUARD_ON   = 32'h1;
  localparam logic [31:0] KICK_DATA      = 32'h0;

  typedef enum logic [2:0] {
    CFG_PERIOD = 3'd0,
    CFG_ENABLE = 3'd1,
    RUN        = 3'd2,
    KICK       = 3'd3,
    STARVE     = 3'd4
  } schedState_t;

  // States in which the scheduler owns the next bus cycle.
  function automatic logic isSchedWrite(schedState_t s);
    return (s == CFG_PERIOD) || (s == CFG_ENABLE) || (s == KICK);
  endfunction

endpackage

// File: rtl/wdog_hb_collector.sv
// rtl/wdog_hb_collector.sv - sticky heartbeat mask with evaluation reload and missed-task latch
module wdog_hb_collector #(
  parameter int NUM_TASKS = 4
) (
  input  logic                 wLB_Clk,
  input  logic                 wLB_Rst,
  input  logic [NUM_TASKS-1:0] bHeartbeat,
  input  logic                 evalNow,
  input  logic                 latchMiss,
  output logic                 allAlive,
  output logic [NUM_TASKS-1:0] bMissedMask
);

  logic [NUM_TASKS-1:0] sticky;

  always_ff @(posedge wLB_Clk or posedge wLB_Rst) begin
    if (wLB_Rst) begin
      sticky      <= '0;
      bMissedMask <= '0;
    end else begin
      // Pulses arriving in the evaluation cycle seed the next window instead of being dropped.
      if (evalNow) sticky <= bHeartbeat;
      else         sticky <= sticky | bHeartbeat;
      if (latchMiss) bMissedMask <= ~sticky;
    end
  end

  assign allAlive = &sticky;

endmodule

// File: rtl/wdog_kick_sched.sv
// rtl/wdog_kick_sched.sv - watchdog config/kick scheduler; host port and arbiter under WDOG_SCHED_HOST_PORT_EN
module wdog_kick_sched
  import wdog_sched_pkg::*;
#(
  parameter int          NUM_TASKS     = 4,
  parameter int          KICK_INTERVAL = 1000,
  parameter logic [31:0] LOAD_VALUE    = 32'd4096
) (
  input  logic                 wLB_Clk,
  input  logic                 wLB_Rst,
  input  logic [NUM_TASKS-1:0] bHeartbeat,
`ifdef WDOG_SCHED_HOST_PORT_EN
  input  logic                 wHost_req,
  input  logic [7:0]           wHost_add,
  input  logic [31:0]          wHost_wr_data,
  output logic                 wHost_ack,
`endif
  output logic                 wLB_wr,
  output logic                 wLB_rd,
  output logic [7:0]           wLB_add,
  output logic [31:0]          wLB_wr_data,
  output logic [NUM_TASKS-1:0] bMissedMask,
  output logic                 wStarved
);

  localparam int               CNT_W      = $clog2(KICK_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(KICK_INTERVAL - 1);

  schedState_t      state;
  logic [CNT_W-1:0] cnt;
  logic             evalNow;
  logic             allAlive;
  logic             latchMiss;

  assign evalNow   = (state == RUN) && (cnt == '0);
  assign latchMiss = evalNow && !allAlive;
  assign wLB_rd    = 1'b0;

`ifdef WDOG_SCHED_HOST_PORT_EN
  // The ack term stops a request still held in its grant cycle from being taken twice.
  logic hostGrant;
  assign hostGrant = wHost_req && !wHost_ack && !isSchedWrite(state);
`endif

  wdog_hb_collector #(
    .NUM_TASKS(NUM_TASKS)
  ) u_collector (
    .wLB_Clk    (wLB_Clk),
    .wLB_Rst    (wLB_Rst),
    .bHeartbeat (bHeartbeat),
    .evalNow    (evalNow),
    .latchMiss  (latchMiss),
    .allAlive   (allAlive),
    .bMissedMask(bMissedMask)
  );

  always_ff @(posedge wLB_Clk or posedge wLB_Rst) begin
    if (wLB_Rst) begin
      state       <= CFG_PERIOD;
      cnt         <= CNT_RELOAD;
      wLB_wr      <= 1'b0;
      wLB_add     <= '0;
      wLB_wr_data <= '0;
      wStarved    <= 1'b0;
`ifdef WDOG_SCHED_HOST_PORT_EN
      wHost_ack   <= 1'b0;
`endif
    end else begin
      wLB_wr      <= 1'b0;
      wLB_add     <= '0;
      wLB_wr_data <= '0;
`ifdef WDOG_SCHED_HOST_PORT_EN
      wHost_ack   <= 1'b0;
`endif
      case (state)
        CFG_PERIOD: begin
          wLB_wr      <= 1'b1;
          wLB_add     <= ADDR_LOAD;
          wLB_wr_data <= LOAD_VALUE;
          state       <= CFG_ENABLE;
        end
        CFG_ENABLE: begin
          wLB_wr      <= 1'b1;
          wLB_add     <= ADDR_SAFEGUARD;
          wLB_wr_data <= SAFEGUARD_ON;
          state       <= RUN;
        end
        RUN: begin
          if (cnt == '0) begin
            cnt <= CNT_RELOAD;
            if (allAlive) begin
              state <= KICK;
            end else begin
              state    <= STARVE;
              wStarved <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        KICK: begin
          // The window keeps counting through the kick so kicks stay one interval apart.
          wLB_wr      <= 1'b1;
          wLB_add     <= ADDR_KICK;
          wLB_wr_data <= KICK_DATA;
          cnt         <= cnt - 1'b1;
          state       <= RUN;
        end
        STARVE: state <= STARVE;
        default: state <= CFG_PERIOD;
      endcase
`ifdef WDOG_SCHED_HOST_PORT_EN
      if (hostGrant) begin
        wLB_wr      <= 1'b1;
        wLB_add     <= wHost_add;
        wLB_wr_data <= wHost_wr_data;
        wHost_ack   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wdog_kick_sched.sv
// tb/tb_wdog_kick_sched.sv - scoreboard bench for wdog_kick_sched against an edge-indexed window model
module tb_wdog_kick_sched;

  localparam int          NT = 4;
  localparam int          KI = 16;
  localparam logic [31:0] LV = 32'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  hb = 4'h0;
  logic        wr;
  logic        rd;
  logic [7:0]  add;
  logic [31:0] wdata;
  logic [3:0]  miss;
  logic        starvedO;
`ifdef WDOG_SCHED_HOST_PORT_EN
  logic        hReq = 1'b0;
  logic [7:0]  hAdd = 8'h0;
  logic [31:0] hData = 32'h0;
  logic        hAck;
  bit          hostOn = 1'b0;
  bit          kickHostDone = 1'b0;
`endif

  wdog_kick_sched #(
    .NUM_TASKS(NT),
    .KICK_INTERVAL(KI),
    .LOAD_VALUE(LV)
  ) dut (
    .wLB_Clk      (clk),
    .wLB_Rst      (rst),
    .bHeartbeat   (hb),
`ifdef WDOG_SCHED_HOST_PORT_EN
    .wHost_req    (hReq),
    .wHost_add    (hAdd),
    .wHost_wr_data(hData),
    .wHost_ack    (hAck),
`endif
    .wLB_wr       (wr),
    .wLB_rd       (rd),
    .wLB_add      (add),
    .wLB_wr_data  (wdata),
    .bMissedMask  (miss),
    .wStarved     (starvedO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          atEdge;
    logic [7:0]  add;
    logic [31:0] data;
    bit          host;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monIt;
  int         checks = 0;
  int         errors = 0;
  int         curEdge = 0;
  int         kickEdge = -1;
  int         starveEdge = 0;
  int         hostGrantEdge = -1;
  bit         starved = 1'b0;
  logic [3:0] expMiss = 4'h0;
  logic [3:0] winSet [0:63];
  int         mode = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, curEdge);
    end
  endtask

  function automatic void push(int at, logic [7:0] a, logic [31:0] d, bit h);
    exp_t it;
    it.atEdge = at; it.add = a; it.data = d; it.host = h;
    expQ.push_back(it);
  endfunction

  // Edges are numbered from reset release; window 1 also holds the two config cycles.
  function automatic int winOf(int n);
    return (n <= KI + 1) ? 1 : (n - 2) / KI + 1;
  endfunction

  function automatic bit isEval(int n);
    return (n >= KI + 2) && ((n - 2) % KI == 0);
  endfunction

  task automatic resetModel();
    expQ.delete();
    for (int i = 0; i < 64; i++) winSet[i] = 4'h0;
    curEdge = 0; kickEdge = -1; starveEdge = 0; starved = 1'b0;
    expMiss = 4'h0; hostGrantEdge = -1;
`ifdef WDOG_SCHED_HOST_PORT_EN
    hReq = 1'b0; kickHostDone = 1'b0;
`endif
  endtask

  // Drive inputs for edge e+1 and queue whatever bus write the rules demand at that edge.
  task automatic prep(int e);
    int n;
    int k;
    bit schedAt;
    n = e + 1;
`ifdef WDOG_SCHED_HOST_PORT_EN
    if (hostGrantEdge == e) hReq = 1'b0;
`endif
    case (mode)
      0:       hb = 4'($urandom_range(0, 15));
      1:       hb = isEval(n) ? 4'hF : 4'h0;
      default: hb = (n % 8 == 0) ? 4'hB : (4'($urandom_range(0, 15)) & 4'hB);
    endcase
    winSet[winOf(n)] |= hb;
    schedAt = (n == 1) || (n == 2) || (n == kickEdge);
    if (n == 1) push(n, 8'h08, LV, 1'b0);
    if (n == 2) push(n, 8'h01, 32'h1, 1'b0);
    if (n == kickEdge) push(n, 8'h04, 32'h0, 1'b0);
    if (!starved && isEval(n)) begin
      k = (n - 2) / KI;
      if (winSet[k] == 4'hF) kickEdge = n + 1;
      else begin
        starved = 1'b1; starveEdge = n; expMiss = ~winSet[k];
      end
    end
`ifdef WDOG_SCHED_HOST_PORT_EN
    if (hostOn) begin
      if (!hReq && !kickHostDone && n == kickEdge) begin
        hReq = 1'b1; hAdd = 8'h08; hData = 32'd55; kickHostDone = 1'b1;
      end else if (!hReq && hostGrantEdge != e && n > 2 && $urandom_range(0, 5) == 0) begin
        hReq = 1'b1; hAdd = 8'($urandom_range(0, 255)); hData = $urandom;
      end
      if (hReq && !schedAt) begin
        push(n, hAdd, hData, 1'b1);
        hostGrantEdge = n;
      end
    end
`endif
  endtask

  task automatic runEdges(int cnt);
    repeat (cnt) begin
      @(posedge clk); #1;
      curEdge++;
      prep(curEdge);
    end
  endtask

  task automatic chkZero(string tag);
    chk({tag, "_wr"}, 32'(wr), 32'h0);
    chk({tag, "_add"}, 32'(add), 32'h0);
    chk({tag, "_data"}, wdata, 32'h0);
    chk({tag, "_miss"}, 32'(miss), 32'h0);
    chk({tag, "_starved"}, 32'(starvedO), 32'h0);
    chk({tag, "_rd"}, 32'(rd), 32'h0);
`ifdef WDOG_SCHED_HOST_PORT_EN
    chk({tag, "_ack"}, 32'(hAck), 32'h0);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (expQ.size() > 0 && expQ[0].atEdge < curEdge) begin
        monIt = expQ.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got none by edge %0d expected add=%0h data=%0h at edge %0d",
                 curEdge, monIt.add, monIt.data, monIt.atEdge);
      end
      if (wr) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got add=%0h data=%0h at edge %0d expected no write",
                   add, wdata, curEdge);
        end else begin
          monIt = expQ.pop_front();
          chk("wr_edge", 32'(curEdge), 32'(monIt.atEdge));
          chk("wr_add", 32'(add), 32'(monIt.add));
          chk("wr_data", wdata, monIt.data);
`ifdef WDOG_SCHED_HOST_PORT_EN
          chk("host_ack", 32'(hAck), 32'(monIt.host));
`endif
        end
      end
`ifdef WDOG_SCHED_HOST_PORT_EN
      else chk("ack_idle", 32'(hAck), 32'h0);
`endif
      chk("starved", 32'(starvedO), 32'(starveEdge > 0 && curEdge >= starveEdge));
      chk("missed_mask", 32'(miss), (starveEdge > 0 && curEdge >= starveEdge) ? 32'(expMiss) : 32'h0);
      chk("rd_zero", 32'(rd), 32'h0);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2 chkZero("reset");
    @(posedge clk); @(posedge clk); #3;
    resetModel(); mode = 0; prep(0); rst = 1'b0;
    runEdges(80);
    mode = 1;
    runEdges(50);
    runEdges($urandom_range(3, 12));
    #2 rst = 1'b1;
    #1 chkZero("midreset");
    resetModel();
    @(posedge clk); @(posedge clk); #3;
    mode = 0;
`ifdef WDOG_SCHED_HOST_PORT_EN
    hostOn = 1'b1;
`endif
    prep(0); rst = 1'b0;
    runEdges(70);
    mode = 2;
    runEdges(60);
    chk("final_missed", 32'(miss), 32'h4);
    chk("final_starved", 32'(starvedO), 32'h1);
    runEdges(3);
    chk("queue_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdog_kick_sched.md
WDOG_KICK_SCHED -- requirements
Module: wdog_kick_sched

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 4: number of monitored heartbeat sources (1..32).
REQ-002 SHALL have parameter KICK_INTERVAL, default 1000: evaluation window in clocks (>=4).
REQ-003 SHALL have parameter LOAD_VALUE, default 32'd4096: watchdog period programmed at start-up.
REQ-004 SHALL have port wLB_Clk, in, 1: the single clock.
REQ-005 SHALL have port wLB_Rst, in, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port bHeartbeat, in, NUM_TASKS: one-cycle alive pulses, one bit per task.
REQ-007 SHALL have port wHost_req, in, 1: host write request, held until acknowledged.
REQ-008 SHALL have port wHost_add, in, 8: host write address.
REQ-009 SHALL have port wHost_wr_data, in, 32: host write data.
REQ-010 SHALL have port wHost_ack, out, 1: one-cycle grant pulse.
REQ-011 SHALL have port wLB_wr, out, 1: local-bus write strobe to the watchdog.
REQ-012 SHALL have port wLB_rd, out, 1: read strobe, constant 0.
REQ-013 SHALL have port wLB_add, out, 8: local-bus address.
REQ-014 SHALL have port wLB_wr_data, out, 32: local-bus write data.
REQ-015 SHALL have port bMissedMask, out, NUM_TASKS: tasks silent in the failing window.
REQ-016 SHALL have port wStarved, out, 1: kicking permanently stopped.

Function
REQ-017 SHALL register all local-bus outputs; wLB_wr is a single-cycle pulse per write.
REQ-018 SHALL use FSM states CFG_PERIOD, CFG_ENABLE, RUN, KICK, STARVE.
REQ-019 SHALL issue a write of LOAD_VALUE to address 0x08 in CFG_PERIOD, then a write of 0x1 to address 0x01 in CFG_ENABLE, then enter RUN.
REQ-020 SHALL, in RUN, count down from KICK_INTERVAL-1; the cycle at count 0 is the evaluation cycle.
REQ-021 SHALL OR heartbeat pulses into a sticky mask during the window.
REQ-022 SHALL, at evaluation with all sticky bits set, go to KICK (one write to address 0x04, data 0), reload the counter and return to RUN.
REQ-023 SHALL, at evaluation with any sticky bit clear, latch bMissedMask = ~sticky, set wStarved and enter STARVE.
REQ-024 SHALL leave STARVE only by reset; no further scheduler writes issue.
REQ-025 SHALL load the sticky mask with the evaluation-cycle bHeartbeat value, so those pulses count toward the next window.
REQ-026 SHALL arbitrate with fixed priority: a pending scheduler write wins; the host is granted in the first cycle with no scheduler write.
REQ-027 SHALL drive wHost_ack in the same cycle as the host's wLB_wr pulse; the host write uses wHost_add and wHost_wr_data unchanged.
REQ-028 SHALL stall a host write by at most one cycle; host writes are accepted in every state, including STARVE.

Reset
REQ-029 SHALL force, on wLB_Rst, state CFG_PERIOD, counter KICK_INTERVAL-1, sticky mask 0 and all outputs 0, immediately and independent of clock.
REQ-030 SHALL, on reset mid-operation, abandon any write in progress and restart the configuration sequence after release.

Configuration
REQ-031 SHALL, with macro WDOG_SCHED_HOST_PORT_EN defined, include the host ports and the arbiter.
REQ-032 SHALL, without WDOG_SCHED_HOST_PORT_EN, omit wHost_req, wHost_add, wHost_wr_data and wHost_ack, and make the scheduler the sole bus master.

Structure
REQ-033 SHALL place the address constants (0x01 safeguard, 0x04 kick, 0x08 load) and the FSM state encoding in the shared package wdog_sched_pkg.
REQ-034 SHALL implement the sticky mask, clear/load and missed-mask latch in the sub-module wdog_hb_collector.

Verification (NUM_TASKS=4, KICK_INTERVAL=16, LOAD_VALUE=100)
REQ-035 SHALL cover reset release: wr(0x08, 100) then wr(0x01, 1) on consecutive cycles, then RUN.
REQ-036 SHALL cover heartbeats 4'b1111 in every window: wr(0x04, 0) once per 16-cycle window, wStarved=0.
REQ-037 SHALL cover task 2 silent for one window: no kick, bMissedMask=4'b0100, wStarved=1, bus idle afterwards.
REQ-038 SHALL cover wHost_req(0x08, 55) raised in a kick cycle: kick first, host write and wHost_ack on the next cycle.
REQ-039 SHALL cover a heartbeat only in the evaluation cycle, repeated in the next window: counts for the next window and the kick occurs.
REQ-040 SHALL cover wLB_Rst asserted mid-window: outputs 0 without a clock edge, and the config sequence repeats after release.
